// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and character width.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    localparam int PAR_NONE  = 0;
    localparam int PAR_ODD   = 1;
    localparam int PAR_EVEN  = 2;
    localparam int DATA_BITS = 8;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input int mode);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses o_tc on the last count.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign o_tc = i_enable && (cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear)
            cnt <= '0;
        else if (i_enable)
            cnt <= o_tc ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops a byte from the TX FIFO when idle and sends
// start, 8 data bits LSB first, optional parity and 1-2 stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_fifo_not_empty,
    input  logic [7:0] i_rd_data,
    output logic       o_rd_en,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 par_q, par_d;
    logic                 ser_d;
    logic                 tc;
    logic                 rd_en_c, done_c;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (state_q == S_IDLE),
        .i_enable (state_q != S_IDLE),
        .o_tc     (tc)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        rd_en_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_fifo_not_empty) begin
                    rd_en_c = 1'b1;
                    shift_d = i_rd_data;
                    par_d   = parity_bit(i_rd_data, PARITY);
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tc) state_d = S_DATA;
            end
            S_DATA: begin
                if (tc) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tc) state_d = S_STOP;
            end
            S_STOP: begin
                // idx_q is reused to count stop bits
                if (tc) begin
                    if (idx_q == LAST_STOP) begin
                        done_c  = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        case (state_d)
            S_START:  ser_d = 1'b0;
            S_DATA:   ser_d = shift_d[0];
            S_PARITY: ser_d = par_q;
            default:  ser_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            par_q       <= 1'b0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            par_q       <= par_d;
            o_tx_serial <= ser_d;
            o_tx_active <= (state_d != S_IDLE);
        end
    end

    // A reset cycle neither pops the FIFO nor reports a completed frame.
    assign o_rd_en   = rd_en_c & ~i_rst;
    assign o_tx_done = done_c & ~i_rst;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: three serializer configurations fed by single-entry FIFO models,
// each frame checked cycle by cycle against the expected framed bit list.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int NI  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NI-1:0] nempty = '0;
    logic [7:0]    rdata [NI];
    wire  [NI-1:0] rd_en, ser, act, dn;

    int cyc  = 0;
    int chks = 0;
    int errs = 0;

    byte unsigned wq    [NI][$];
    byte unsigned exp_q [NI][$];
    logic [NI-1:0] popd = '0;

    logic [11:0] fbits  [NI];
    int          fstart [NI];
    int          fend   [NI];
    bit          fvalid [NI];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // inst0: no parity, 1 stop; inst1: even, 2 stop; inst2: odd, 1 stop
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int P = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int S = (g == 1) ? 2 : 1;
        uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(P), .STOP_BITS(S)) u_dut (
            .i_clk            (clk),
            .i_rst            (rst),
            .i_fifo_not_empty (nempty[g]),
            .i_rd_data        (rdata[g]),
            .o_rd_en          (rd_en[g]),
            .o_tx_serial      (ser[g]),
            .o_tx_active      (act[g]),
            .o_tx_done        (dn[g])
        );
    end

    function automatic int par_of(input int g);
        return (g == 1) ? 2 : (g == 2) ? 1 : 0;
    endfunction

    function automatic int stop_of(input int g);
        return (g == 1) ? 2 : 1;
    endfunction

    function automatic int nbits_of(input int g);
        return 1 + 8 + ((par_of(g) != 0) ? 1 : 0) + stop_of(g);
    endfunction

    // Bit i of the result is the line level during bit period i of the frame.
    function automatic logic [11:0] frame_of(input int g, input logic [7:0] b);
        logic [11:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        if (par_of(g) == 2) f[9] = (ones % 2 == 1);
        if (par_of(g) == 1) f[9] = (ones % 2 == 0);
        return f;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] want);
        chks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, g, cyc, got, want);
        end
    endtask

    function automatic bit all_idle();
        for (int g = 0; g < NI; g++)
            if (wq[g].size() != 0 || nempty[g] || fvalid[g] || exp_q[g].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: compares every cycle against the frame popped from the scoreboard.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int g = 0; g < NI; g++) begin
                bit inf;
                byte unsigned b;
                inf = fvalid[g] && cyc >= fstart[g] && cyc <= fend[g];
                if (inf) chk("line", g, 32'(ser[g]), 32'(fbits[g][(cyc - fstart[g]) / CPB]));
                else     chk("line_idle", g, 32'(ser[g]), 32'd1);
                chk("active", g, 32'(act[g]), 32'(inf));
                chk("done", g, 32'(dn[g]), 32'(inf && cyc == fend[g] && !rst));
                chk("rd_en", g, 32'(rd_en[g]), 32'(!rst && !inf && nempty[g]));
                popd[g] = rd_en[g];
                if (rst || (inf && cyc == fend[g])) fvalid[g] = 1'b0;
                if (rd_en[g] && !rst) begin
                    chk("sb_pop", g, 32'(exp_q[g].size() != 0), 32'd1);
                    if (exp_q[g].size() != 0) begin
                        b         = exp_q[g].pop_front();
                        fbits[g]  = frame_of(g, b);
                        fvalid[g] = 1'b1;
                        fstart[g] = cyc + 1;
                        fend[g]   = cyc + nbits_of(g) * CPB;
                    end
                end
            end
        end
    end

    // FIFO model: holds one byte, refills from the write list once popped.
    initial begin
        for (int g = 0; g < NI; g++) rdata[g] = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < NI; g++) begin
                if (popd[g]) begin
                    nempty[g] = 1'b0;
                    popd[g]   = 1'b0;
                end
                if (!nempty[g] && wq[g].size() > 0) begin
                    rdata[g]  = wq[g].pop_front();
                    nempty[g] = 1'b1;
                    exp_q[g].push_back(rdata[g]);
                end else if (!nempty[g]) begin
                    rdata[g] = 8'($urandom);
                end
            end
        end
    end

    task automatic push_all(input logic [7:0] b);
        for (int g = 0; g < NI; g++) wq[g].push_back(b);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (n < bound && !all_idle()) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 0, 32'(all_idle()), 32'd1);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        push_all(8'hA5); wait_idle(400);
        push_all(8'h07); wait_idle(400);
        push_all(8'h00); wait_idle(400);

        push_all(8'h55); push_all(8'h3C); wait_idle(400);

        // Reset while inst0 is in data bit 3; 0x96 is dropped, 0x5A must follow cleanly.
        push_all(8'h96); push_all(8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rd_en[0];
        end
        chk("pop_before_reset", 0, 32'(seen), 32'd1);
        repeat (18) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle(400);

        repeat (100) @(posedge clk);
        #1 push_all(8'hC3);
        wait_idle(400);

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 60)) @(posedge clk);
            #1;
            for (int g = 0; g < NI; g++) wq[g].push_back(8'($urandom_range(0, 255)));
        end
        wait_idle(5000);

        $display("CHECKS %0d ERRORS %0d", chks, errs);
        $finish;
    end

endmodule
